// File: rtl/mac_da_fltr_multi_if.sv
// GMII receive path and configuration bus for the multi-address DA filter.
// The bench side drives the master modport, the filter uses the slave modport.
interface mac_da_fltr_multi_if;
  logic        RXDV;
  logic [7:0]  RXD;
  logic        RXERI;
  logic        RXDV_O;
  logic [7:0]  RXD_O;
  logic        RXERO;
  logic        CFG_WE;
  logic [7:0]  CFG_ADDR;
  logic [31:0] CFG_WDATA;
  logic [31:0] CFG_RDATA;

  modport master (
    output RXDV, RXD, RXERI, CFG_WE, CFG_ADDR, CFG_WDATA,
    input  RXDV_O, RXD_O, RXERO, CFG_RDATA
  );

  modport slave (
    input  RXDV, RXD, RXERI, CFG_WE, CFG_ADDR, CFG_WDATA,
    output RXDV_O, RXD_O, RXERO, CFG_RDATA
  );
endinterface

// File: rtl/mac_da_fltr_multi.sv
// Inline GMII receive filter: checks the destination address against a table plus
// broadcast/multicast/promiscuous modes and poisons rejected frames via RXERO.
module mac_da_fltr_multi #(
  parameter int         NUM_ADDR = 4,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] CTRL_RST = 4'b0101
) (
  input  logic                RXCLK,
  input  logic                RESETN,
  mac_da_fltr_multi_if.slave  bus,
  output logic [CNT_W-1:0]    PASS_CNT,
  output logic [CNT_W-1:0]    DROP_CNT
);

  typedef enum logic [2:0] {IDLE, PRE, DA, ACCEPT, REJECT, THRU} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [2:0]         r_byte_cnt;
  logic [39:0]        r_da;
  logic [3:0]         r_ctrl;
  logic [47:0]        r_mac [NUM_ADDR];
  logic [NUM_ADDR-1:0] r_vld;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_drop;
  logic [31:0]        r_rdata;
  logic [31:0]        w_rdata;
  logic               r_rxdv_o;
  logic [7:0]         r_rxd_o;
  logic               r_rxero;

  logic [47:0]        w_da;
  logic [NUM_ADDR-1:0] w_hit;
  logic               w_bcast;
  logic               w_mcast;
  logic               w_accept;
  logic               w_decide;
  logic               w_kill;
  logic               w_cnt_clr;
  logic               w_unused;

  // Last DA byte is still on RXD when the decision is taken
  assign w_da    = {r_da, bus.RXD};
  assign w_bcast = &w_da;
  assign w_mcast = w_da[40] & ~w_bcast;

  generate
    for (genvar gi = 0; gi < NUM_ADDR; gi++) begin : g_hit
      assign w_hit[gi] = r_vld[gi] && (r_mac[gi] == w_da);
    end
  endgenerate

  assign w_accept  = ~r_ctrl[0] | r_ctrl[1] | (w_bcast & r_ctrl[2]) |
                     (w_mcast & r_ctrl[3]) | (|w_hit);
  assign w_decide  = (r_state == DA) && bus.RXDV && (r_byte_cnt == 3'd5);
  assign w_kill    = (r_state == REJECT) && bus.RXDV;
  assign w_cnt_clr = bus.CFG_WE && (bus.CFG_ADDR == 8'h01);
  assign w_unused  = ^bus.CFG_WDATA[30:16];

  always_ff @(posedge RXCLK) begin
    if (!RESETN) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (!bus.RXDV) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE, PRE: begin
          if (bus.RXD == 8'h55)      w_state_next = PRE;
          else if (bus.RXD == 8'hD5) w_state_next = DA;
          else                       w_state_next = THRU;
        end
        DA: begin
          if (w_decide) w_state_next = w_accept ? ACCEPT : REJECT;
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  always_ff @(posedge RXCLK) begin
    if (!RESETN) begin
      r_rxdv_o   <= 1'b0;
      r_rxd_o    <= 8'h00;
      r_rxero    <= 1'b0;
      r_byte_cnt <= 3'd0;
      r_da       <= 40'd0;
    end else begin
      r_rxdv_o <= bus.RXDV;
      r_rxd_o  <= bus.RXD;
      r_rxero  <= bus.RXERI | w_kill;
      if (r_state == DA) begin
        r_da       <= {r_da[31:0], bus.RXD};
        r_byte_cnt <= r_byte_cnt + 3'd1;
      end else begin
        r_byte_cnt <= 3'd0;
      end
    end
  end

  // Clear from the config bus takes priority over a same-cycle increment
  always_ff @(posedge RXCLK) begin
    if (!RESETN || w_cnt_clr) begin
      r_pass <= '0;
      r_drop <= '0;
    end else if (w_decide) begin
      if (w_accept && !(&r_pass)) r_pass <= r_pass + 1'b1;
      if (!w_accept && !(&r_drop)) r_drop <= r_drop + 1'b1;
    end
  end

  always_ff @(posedge RXCLK) begin
    if (!RESETN) begin
      r_ctrl <= CTRL_RST;
      r_vld  <= '0;
      for (int k = 0; k < NUM_ADDR; k++) r_mac[k] <= 48'd0;
    end else if (bus.CFG_WE) begin
      if (bus.CFG_ADDR == 8'h00) r_ctrl <= bus.CFG_WDATA[3:0];
      for (int k = 0; k < NUM_ADDR; k++) begin
        if (bus.CFG_ADDR == 8'(2 + 2 * k)) r_mac[k][31:0] <= bus.CFG_WDATA;
        if (bus.CFG_ADDR == 8'(3 + 2 * k)) begin
          r_mac[k][47:32] <= bus.CFG_WDATA[15:0];
          r_vld[k]        <= bus.CFG_WDATA[31];
        end
      end
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    if (bus.CFG_ADDR == 8'h00) w_rdata = {28'd0, r_ctrl};
    if (bus.CFG_ADDR == 8'h01) w_rdata = {16'(r_drop), 16'(r_pass)};
    for (int k = 0; k < NUM_ADDR; k++) begin
      if (bus.CFG_ADDR == 8'(2 + 2 * k)) w_rdata = r_mac[k][31:0];
      if (bus.CFG_ADDR == 8'(3 + 2 * k)) w_rdata = {r_vld[k], 15'd0, r_mac[k][47:32]};
    end
  end

  always_ff @(posedge RXCLK) begin
    if (!RESETN) r_rdata <= 32'd0;
    else         r_rdata <= w_rdata;
  end

  assign bus.RXDV_O    = r_rxdv_o;
  assign bus.RXD_O     = r_rxd_o;
  assign bus.RXERO     = r_rxero;
  assign bus.CFG_RDATA = r_rdata;
  assign PASS_CNT      = r_pass;
  assign DROP_CNT      = r_drop;

endmodule

// File: tb/tb_mac_da_fltr_multi.sv
// Scoreboard bench: frames are classified by a frame-level reference model when issued;
// a monitor compares every output cycle, and a CNT_W=2 copy checks counter saturation.
module tb_mac_da_fltr_multi;
  localparam int NA = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  mac_da_fltr_multi_if bus ();
  mac_da_fltr_multi_if bus2 ();
  logic [15:0] pass_cnt, drop_cnt;
  logic [1:0]  pass2, drop2;

  assign bus2.RXDV      = bus.RXDV;
  assign bus2.RXD       = bus.RXD;
  assign bus2.RXERI     = bus.RXERI;
  assign bus2.CFG_WE    = bus.CFG_WE;
  assign bus2.CFG_ADDR  = bus.CFG_ADDR;
  assign bus2.CFG_WDATA = bus.CFG_WDATA;

  mac_da_fltr_multi #(.NUM_ADDR(NA), .CNT_W(16), .CTRL_RST(4'b0101)) u_dut (
    .RXCLK(clk), .RESETN(rstn), .bus(bus), .PASS_CNT(pass_cnt), .DROP_CNT(drop_cnt));

  mac_da_fltr_multi #(.NUM_ADDR(NA), .CNT_W(2), .CTRL_RST(4'b0101)) u_dut2 (
    .RXCLK(clk), .RESETN(rstn), .bus(bus2), .PASS_CNT(pass2), .DROP_CNT(drop2));

  typedef struct {
    bit          dv;
    logic [7:0]  d;
    bit          er;
    bit          chk_rd;
    logic [31:0] rd;
    bit          chk_cnt;
    int          pass;
    int          drop;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [3:0]  m_ctrl;
  logic [47:0] m_mac [NA];
  bit          m_vld [NA];
  int          m_pass, m_drop;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      chk("RXDV_O", 32'(bus.RXDV_O), 32'(me.dv));
      chk("RXD_O", 32'(bus.RXD_O), 32'(me.d));
      chk("RXERO", 32'(bus.RXERO), 32'(me.er));
      if (me.chk_rd) chk("CFG_RDATA", bus.CFG_RDATA, me.rd);
      if (me.chk_cnt) begin
        chk("PASS_CNT", 32'(pass_cnt), 32'(sat(me.pass, 65535)));
        chk("DROP_CNT", 32'(drop_cnt), 32'(sat(me.drop, 65535)));
        chk("PASS_CNT_W2", 32'(pass2), 32'(sat(me.pass, 3)));
        chk("DROP_CNT_W2", 32'(drop2), 32'(sat(me.drop, 3)));
      end
      $display("cyc t=%0t dv=%0d d=%02h er=%0d", $time, me.dv, me.d, me.er);
    end
  end

  function automatic logic [31:0] model_rd(input logic [7:0] a);
    logic [31:0] r;
    r = 32'd0;
    if (a == 8'h00) r = {28'd0, m_ctrl};
    if (a == 8'h01) r = {16'(sat(m_drop, 65535)), 16'(sat(m_pass, 65535))};
    for (int k = 0; k < NA; k++) begin
      if (a == 8'(2 + 2 * k)) r = m_mac[k][31:0];
      if (a == 8'(3 + 2 * k)) r = {m_vld[k], 15'd0, m_mac[k][47:32]};
    end
    return r;
  endfunction

  task automatic model_reset;
    m_ctrl = 4'h5;
    m_pass = 0;
    m_drop = 0;
    for (int k = 0; k < NA; k++) begin
      m_mac[k] = 48'd0;
      m_vld[k] = 1'b0;
    end
  endtask

  // 0 = not classified (no SFD / truncated), 1 = accept, 2 = reject
  function automatic int classify(input logic [7:0] fr[$], output int kf);
    int i;
    logic [47:0] da;
    bit bc, hit;
    kf = 0;
    i = 0;
    da = 48'd0;
    while (i < fr.size() && fr[i] == 8'h55) i++;
    if (i >= fr.size()) return 0;
    if (fr[i] != 8'hD5) return 0;
    if (fr.size() < i + 7) return 0;
    for (int k = 0; k < 6; k++) da = {da[39:0], fr[i + 1 + k]};
    kf = i + 7;
    bc = (da == 48'hFFFF_FFFF_FFFF);
    hit = 1'b0;
    for (int k = 0; k < NA; k++) if (m_vld[k] && m_mac[k] == da) hit = 1'b1;
    if (!m_ctrl[0] || m_ctrl[1] || (bc && m_ctrl[2]) || (da[40] && !bc && m_ctrl[3]) || hit)
      return 1;
    return 2;
  endfunction

  task automatic count(input int res);
    if (res == 1) m_pass++;
    if (res == 2) m_drop++;
  endtask

  task automatic push(input bit dv, input logic [7:0] d, input bit er,
                      input bit chk_rd, input logic [31:0] rd, input bit chk_cnt);
    exp_t e;
    e.dv = dv; e.d = d; e.er = er; e.chk_rd = chk_rd; e.rd = rd;
    e.chk_cnt = chk_cnt; e.pass = m_pass; e.drop = m_drop;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic cfg_wr(input logic [7:0] a, input logic [31:0] w);
    bus.CFG_WE = 1'b1;
    bus.CFG_ADDR = a;
    bus.CFG_WDATA = w;
    push(1'b0, 8'h00, 1'b0, 1'b0, 32'd0, 1'b0);
    tick;
    bus.CFG_WE = 1'b0;
    if (a == 8'h00) m_ctrl = w[3:0];
    if (a == 8'h01) begin m_pass = 0; m_drop = 0; end
    for (int k = 0; k < NA; k++) begin
      if (a == 8'(2 + 2 * k)) m_mac[k][31:0] = w;
      if (a == 8'(3 + 2 * k)) begin m_mac[k][47:32] = w[15:0]; m_vld[k] = w[31]; end
    end
  endtask

  task automatic cfg_rd(input logic [7:0] a);
    bus.CFG_ADDR = a;
    push(1'b0, 8'h00, 1'b0, 1'b1, model_rd(a), 1'b1);
    tick;
  endtask

  function automatic void build(input int npre, input logic [47:0] da, input int npay,
                                output logic [7:0] fr[$]);
    fr = {};
    for (int k = 0; k < npre; k++) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int k = 5; k >= 0; k--) fr.push_back(da[8*k +: 8]);
    for (int k = 0; k < npay; k++) fr.push_back(8'($urandom_range(255)));
  endfunction

  // Drives one frame plus a 1-cycle gap; rst_at >= 0 pulses reset on that byte
  task automatic send(input logic [7:0] fr[$], input int rst_at, input int er_rate);
    int kf, kf2, res;
    logic [7:0] rem[$];
    bit er;
    res = classify(fr, kf);
    count(res);
    for (int i = 0; i < fr.size(); i++) begin
      er = ($urandom_range(99) < er_rate);
      bus.RXDV = 1'b1;
      bus.RXD = fr[i];
      bus.RXERI = er;
      if (i == rst_at) begin
        rstn = 1'b0;
        model_reset();
        push(1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b1);
        rem = {};
        for (int k = i + 1; k < fr.size(); k++) rem.push_back(fr[k]);
        res = classify(rem, kf2);
        count(res);
        kf = i + 1 + kf2;
      end else begin
        push(1'b1, fr[i], er | (res == 2 && i >= kf), 1'b0, 32'd0, 1'b0);
      end
      tick;
      rstn = 1'b1;
    end
    bus.RXDV = 1'b0;
    bus.RXD = 8'h00;
    bus.RXERI = 1'b0;
    push(1'b0, 8'h00, 1'b0, 1'b0, 32'd0, 1'b1);
    tick;
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [47:0] da;
    int k;
    bus.RXDV = 1'b0; bus.RXD = 8'h00; bus.RXERI = 1'b0;
    bus.CFG_WE = 1'b0; bus.CFG_ADDR = 8'h00; bus.CFG_WDATA = 32'd0;
    rstn = 1'b0;
    model_reset();
    push(1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b1);
    tick;
    push(1'b0, 8'h00, 1'b0, 1'b1, 32'd0, 1'b1);
    tick;
    rstn = 1'b1;
    cfg_rd(8'h00);
    cfg_rd(8'h03);

    // unknown unicast rejected at defaults, then accepted via table entry 0
    build(7, 48'h0200_0000_0001, 60, fr);
    send(fr, -1, 0);
    cfg_rd(8'h01);
    cfg_wr(8'h03, 32'h8000_0200);
    cfg_wr(8'h02, 32'h0000_0001);
    cfg_rd(8'h03);
    cfg_rd(8'h02);
    build(7, 48'h0200_0000_0001, 60, fr);
    send(fr, -1, 0);
    cfg_rd(8'h01);

    // broadcast: accepted with BCAST_EN, killed with only MCAST_EN
    build(7, 48'hFFFF_FFFF_FFFF, 20, fr);
    send(fr, -1, 0);
    cfg_wr(8'h00, 32'h9);
    build(7, 48'hFFFF_FFFF_FFFF, 20, fr);
    send(fr, -1, 0);

    // multicast under MCAST_EN, PROMISC and filter disabled
    build(7, 48'h0100_5E00_0001, 20, fr);
    send(fr, -1, 0);
    cfg_wr(8'h00, 32'h3);
    build(7, 48'h0100_5E00_0001, 20, fr);
    send(fr, -1, 0);
    cfg_wr(8'h00, 32'h0);
    build(7, 48'h0100_5E00_0001, 20, fr);
    send(fr, -1, 0);
    cfg_rd(8'h01);

    // no SFD, and truncated DA, with filtering enabled
    cfg_wr(8'h00, 32'h5);
    fr = {};
    for (int i = 0; i < 20; i++) fr.push_back(8'h12 + 8'(i));
    send(fr, -1, 0);
    build(7, 48'h0200_0000_0077, 0, fr);
    while (fr.size() > 11) void'(fr.pop_back());
    send(fr, -1, 0);

    // unmapped address accesses
    cfg_wr(8'h40, 32'hDEAD_BEEF);
    cfg_rd(8'h40);
    cfg_rd(8'(2 + 2 * NA));

    // randomized traffic with config changes and RXERI noise
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(3) == 0) cfg_wr(8'h00, 32'($urandom_range(15)));
      if ($urandom_range(3) == 0) begin
        k = $urandom_range(NA - 1);
        cfg_wr(8'(2 + 2 * k), $urandom());
        cfg_wr(8'(3 + 2 * k), $urandom());
        cfg_rd(8'(3 + 2 * k));
      end
      if ($urandom_range(15) == 0) cfg_wr(8'h01, 32'd0);
      da[47:16] = $urandom();
      da[15:0] = 16'($urandom_range(65535));
      case ($urandom_range(3))
        0: da = m_mac[$urandom_range(NA - 1)];
        1: da = 48'hFFFF_FFFF_FFFF;
        2: da[40] = 1'b1;
        default: da[40] = 1'b0;
      endcase
      build($urandom_range(7), da, $urandom_range(4, 30), fr);
      send(fr, -1, 5);
      cfg_rd(8'h01);
      cfg_rd(8'h00);
    end

    // reset pulse mid-payload of a rejected frame, remainder goes THRU
    cfg_wr(8'h00, 32'h5);
    cfg_wr(8'h03, 32'h0000_0000);
    build(7, 48'h0200_0000_0099, 30, fr);
    fr[25] = 8'hAA;
    send(fr, 24, 0);
    cfg_rd(8'h00);

    // saturation of the 2-bit counter copy
    for (int n = 0; n < 4; n++) begin
      build(7, 48'h0200_0000_0099, 10, fr);
      send(fr, -1, 0);
    end
    cfg_rd(8'h01);

    tick;
    tick;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_da_fltr_multi.md
Name: mac_da_fltr_multi

Overview:
- Parametrised successor to the single-mode GMII frame filter.
- Sits inline on the GMII receive path (RXCLK domain) between the PHY/PCS receive output and the MAC.
- Decodes the preamble/SFD, captures the 6-byte destination address (DA) and checks it against NUM_ADDR programmable unicast entries plus broadcast, multicast and promiscuous modes.
- Passes accepted frames unchanged after a 1-cycle delay. Rejected frames get RXERO forced high for the rest of the frame so the MAC discards them. Saturating pass/drop counters are kept.

Parameters:
- NUM_ADDR, 4, number of DA table entries (1..64).
- CNT_W, 16, pass/drop counter width (1..16).
- CTRL_RST, 4'b0101, reset value of CTRL[3:0].

Ports:
- RXCLK  in  1  receive clock (125/25/2.5 MHz); the only clock.
- RESETN  in  1  synchronous, active-low reset.
- RXDV  in  1  GMII receive data valid.
- RXD  in  8  GMII receive data.
- RXERI  in  1  GMII receive error in.
- RXDV_O  out  1  RXDV delayed 1 cycle.
- RXD_O  out  8  RXD delayed 1 cycle.
- RXERO  out  1  RXERI delayed 1 cycle, OR reject kill.
- CFG_WE  in  1  config write strobe.
- CFG_ADDR  in  8  config word address.
- CFG_WDATA  in  32  config write data.
- CFG_RDATA  out  32  config read data (registered).
- PASS_CNT  out  CNT_W  accepted-frame count.
- DROP_CNT  out  CNT_W  rejected-frame count.

Behaviour:
- Reset: synchronous, active-low, on the RXCLK edge with RESETN=0.
  - RXDV_O, RXD_O, RXERO, CFG_RDATA, PASS_CNT and DROP_CNT go to 0.
  - State goes to IDLE. CTRL is loaded with CTRL_RST. All table entries become invalid with MAC=0.
- Register map, one word per CFG_ADDR:
  - 0x00 CTRL: [0] FLT_EN, [1] PROMISC, [2] BCAST_EN, [3] MCAST_EN.
  - 0x01: read returns {DROP_CNT, PASS_CNT}, each zero-extended to 16 bits. Any write clears both counters.
  - 0x02+2i: entry i MAC[31:0].
  - 0x03+2i: [15:0] MAC[47:32], [31] VALID.
  - Unmapped addresses read 0; writes to them are ignored.
  - CFG_RDATA = word at CFG_ADDR, registered (1-cycle latency, updated every cycle). Writes take effect the next cycle.
- Byte order: the first DA byte received is MAC[47:40]. Multicast bit = DA[40] (LSB of the first byte).
- Datapath: RXDV_O/RXD_O = RXDV/RXD registered; RXERO = registered (RXERI OR state==REJECT). No other modification.
- State machine (evaluated every cycle; RXDV=0 in any state -> IDLE next cycle):
  - IDLE:
    - RXDV=1 and RXD=0x55 -> PRE.
    - RXDV=1 and RXD=0xD5 -> DA (byte counter=0).
    - RXDV=1 with any other byte -> THRU. This also covers a reset release mid-frame.
  - PRE: 0x55 stays in PRE; 0xD5 -> DA; any other byte -> THRU.
  - DA: shift RXD into the DA register and increment the counter. On the 6th byte, decide using the 5 captured bytes plus the current RXD:
    - ACCEPT if FLT_EN=0, or PROMISC=1, or (DA=FF:FF:FF:FF:FF:FF and BCAST_EN), or (DA[40]=1, DA not broadcast, and MCAST_EN), or any entry with VALID=1 and MAC==DA.
    - Broadcast with BCAST_EN=0 -> REJECT, even if MCAST_EN=1.
    - Otherwise REJECT.
    - The decision uses CTRL and table contents as registered in that cycle.
  - ACCEPT / REJECT / THRU: hold until RXDV=0.
- Kill timing:
  - DA byte 5 is output with RXERO equal to the delayed RXERI.
  - The first post-DA byte (SA byte 0) and every later byte of a rejected frame are output with RXERO=1.
  - RXERO returns to the delayed RXERI in the cycle RXDV_O falls.
- Counters:
  - PASS_CNT increments on the DA->ACCEPT transition; DROP_CNT increments on DA->REJECT. Both saturate at all-ones.
  - THRU frames and frames truncated in PRE/DA are not counted and not killed.
  - A clear write and an increment in the same cycle: the clear wins (result 0).
- RXERI asserted mid-frame is passed through and does not alter the decision or the counts.
- Back-to-back frames with a 1-cycle RXDV gap must be classified independently.

Test Plan:
- Reset defaults (CTRL=0x5, no entries). Send 7x0x55, 0xD5, DA=02:00:00:00:00:01, 60 payload bytes -> RXERO=1 from the SA0 output cycle to frame end; DROP_CNT=1, PASS_CNT=0; RXD_O equals RXD delayed 1 cycle throughout.
- Write 0x03=0x8000_0200, 0x02=0x0000_0001, then resend the same frame -> RXERO stays 0 for the whole frame; PASS_CNT=1; reading 0x01 returns 0x0001_0001.
- DA=FF:FF:FF:FF:FF:FF with CTRL=0x5, then CTRL=0x9 -> first frame accepted; second frame killed, with DROP_CNT incremented (broadcast is not covered by MCAST_EN).
- DA=01:00:5E:00:00:01 with CTRL=0x9 -> accepted; with CTRL=0x3 (PROMISC) -> accepted; with CTRL=0x0 -> accepted, PASS_CNT+1 each time.
- Frame with no SFD (RXDV high, bytes 0x12...), and a frame whose RXDV drops after 3 DA bytes -> both passed unmodified with RXERO=0; counters unchanged.
- Assert RESETN=0 for 1 cycle mid-payload of a rejected frame -> all outputs 0 on the next edge; after release the remainder is routed THRU with RXERO=0. With CNT_W=2, four rejected frames -> DROP_CNT holds at 3.
